// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, issues imem reads over a req/ack
// handshake, and reports busy/overrun to the Controller's sequencer.
module fetch_unit #(
  parameter int                    PC_WIDTH    = 8,
  parameter int                    INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     LoadIR,
  input  logic                     IncPC,
  input  logic                     SelPC,
  input  logic                     LoadPC,
  input  logic [PC_WIDTH-1:0]      branch_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  output logic [PC_WIDTH-1:0]      PC,
  output logic [INSTR_WIDTH-1:0]   IR,
  output logic [3:0]               Opcode,
  output logic [INSTR_WIDTH-5:0]   Operand,
  output logic                     ir_valid,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [PC_WIDTH-1:0]     addr_q, addr_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic                    ir_valid_q, ir_valid_d;
  logic                    overrun_q, overrun_d;
  logic [PC_WIDTH-1:0]     pc_inc;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  // PC sequencing runs every cycle regardless of fetch state
  always_comb begin
    pc_d = pc_q;
    if (LoadPC)
      pc_d = SelPC ? branch_addr : pc_inc;
    else if (IncPC)
      pc_d = pc_inc;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    overrun_d  = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (LoadIR) begin
          addr_d     = pc_q;
          ir_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // A request on the completing cycle is still an overrun, never a restart
        if (LoadIR)
          overrun_d = 1'b1;
        if (imem_ack) begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // The request line and busy are both the registered REQ state
  assign imem_req  = (state_q == REQ);
  assign busy      = (state_q == REQ);
  assign imem_addr = addr_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign Opcode    = ir_q[INSTR_WIDTH-1 -: 4];
  assign Operand   = ir_q[INSTR_WIDTH-5:0];
  assign ir_valid  = ir_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected instructions are queued when a
// fetch is launched and compared when the fetch completes.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, LoadIR, IncPC, SelPC, LoadPC, imem_ack;
  logic [7:0] branch_addr, imem_rdata;
  logic       imem_req, ir_valid, busy, overrun;
  logic [7:0] imem_addr, PC, IR;
  logic [3:0] Opcode, Operand;

  logic [7:0] mem [256];
  logic [7:0] sb [$];
  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .branch_addr(branch_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .PC(PC), .IR(IR), .Opcode(Opcode), .Operand(Operand), .ir_valid(ir_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; imem_ack = 0;
  endtask

  task automatic set_pc(input logic [7:0] v);
    LoadPC = 1; SelPC = 1; branch_addr = v;
    tick;
    LoadPC = 0; SelPC = 0;
  endtask

  // Memory responder: waits (bounded) for a request, acks it, and scores IR.
  task automatic mem_respond(input bit loadir_on_ack);
    logic [7:0] exp;
    int n = 0;
    while (!imem_req && n < 20) begin tick; n++; end
    total_cnt++;
    if (imem_req !== 1'b1) $display("FAIL req_timeout got imem_req=%b want 1", imem_req);
    else pass_cnt++;
    imem_ack = 1; imem_rdata = mem[imem_addr]; LoadIR = loadir_on_ack;
    tick;
    imem_ack = 0; LoadIR = 0;
    total_cnt++;
    if (sb.size() == 0) $display("FAIL sb_empty got IR=%h want queued entry", IR);
    else begin
      exp = sb.pop_front();
      if (IR !== exp) $display("FAIL sb_ir got %h want %h", IR, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset;
    clear_inputs; branch_addr = 0; imem_rdata = 0; reset = 1;
    tick; tick;
    reset = 0;
    total_cnt++; if ({PC, IR, imem_addr} !== 24'h0) $display("FAIL rst_regs got PC=%h IR=%h addr=%h want 00/00/00", PC, IR, imem_addr); else pass_cnt++;
    total_cnt++; if ({ir_valid, imem_req, busy, overrun} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {ir_valid, imem_req, busy, overrun}); else pass_cnt++;
  endtask

  task automatic test_fetch;
    LoadIR = 1; IncPC = 1; sb.push_back(mem[8'h00]);
    tick;
    LoadIR = 0; IncPC = 0;
    total_cnt++; if ({imem_req, busy, imem_addr, PC} !== {2'b11, 8'h00, 8'h01}) $display("FAIL fetch_issue got req=%b busy=%b addr=%h PC=%h want 1 1 00 01", imem_req, busy, imem_addr, PC); else pass_cnt++;
    mem_respond(0);
    total_cnt++; if ({Opcode, Operand} !== 8'h1A) $display("FAIL fetch_fields got %h/%h want 1/A", Opcode, Operand); else pass_cnt++;
    total_cnt++; if ({ir_valid, busy, imem_req} !== 3'b100) $display("FAIL fetch_done got valid=%b busy=%b req=%b want 1 0 0", ir_valid, busy, imem_req); else pass_cnt++;
  endtask

  task automatic test_wait_states;
    set_pc(8'h05);
    LoadIR = 1; sb.push_back(mem[8'h05]);
    tick;
    LoadIR = 0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if ({imem_req, busy, imem_addr} !== {2'b11, 8'h05}) $display("FAIL wait_hold%0d got req=%b busy=%b addr=%h want 1 1 05", i, imem_req, busy, imem_addr); else pass_cnt++;
      LoadIR = (i == 0); IncPC = (i == 0);
      tick;
      LoadIR = 0; IncPC = 0;
    end
    total_cnt++; if ({overrun, PC} !== {1'b1, 8'h06}) $display("FAIL wait_overrun got ovr=%b PC=%h want 1 06", overrun, PC); else pass_cnt++;
    mem_respond(0);
    total_cnt++; if ({ir_valid, busy} !== 2'b10) $display("FAIL wait_done got valid=%b busy=%b want 1 0", ir_valid, busy); else pass_cnt++;
  endtask

  task automatic test_jump_priority;
    set_pc(8'h10);
    SelPC = 1; LoadPC = 1; IncPC = 1; branch_addr = 8'h40;
    tick;
    total_cnt++; if (PC !== 8'h40) $display("FAIL jump_branch got PC=%h want 40", PC); else pass_cnt++;
    SelPC = 0; LoadPC = 1; IncPC = 0;
    tick;
    LoadPC = 0;
    total_cnt++; if (PC !== 8'h41) $display("FAIL jump_seq got PC=%h want 41", PC); else pass_cnt++;
  endtask

  task automatic test_wrap;
    set_pc(8'hFF);
    IncPC = 1; LoadIR = 1; sb.push_back(mem[8'hFF]);
    tick;
    IncPC = 0; LoadIR = 0;
    total_cnt++; if ({PC, imem_addr, imem_req} !== {8'h00, 8'hFF, 1'b1}) $display("FAIL wrap got PC=%h addr=%h req=%b want 00 FF 1", PC, imem_addr, imem_req); else pass_cnt++;
    mem_respond(0);
  endtask

  task automatic test_reset_mid_fetch;
    set_pc(8'h22);
    LoadIR = 1;
    tick;
    LoadIR = 0;
    total_cnt++; if ({imem_req, imem_addr} !== {1'b1, 8'h22}) $display("FAIL midrst_pre got req=%b addr=%h want 1 22", imem_req, imem_addr); else pass_cnt++;
    reset = 1;
    tick;
    reset = 0; sb.delete();
    total_cnt++; if ({imem_req, busy, ir_valid, overrun, PC, IR} !== {4'b0, 8'h00, 8'h00}) $display("FAIL midrst_post got req=%b busy=%b valid=%b ovr=%b PC=%h IR=%h want 0 0 0 0 00 00", imem_req, busy, ir_valid, overrun, PC, IR); else pass_cnt++;
    imem_ack = 1; imem_rdata = 8'h77;
    tick;
    imem_ack = 0;
    total_cnt++; if ({IR, ir_valid, imem_req} !== {8'h00, 2'b00}) $display("FAIL midrst_stray got IR=%h valid=%b req=%b want 00 0 0", IR, ir_valid, imem_req); else pass_cnt++;
  endtask

  task automatic test_spurious_ack;
    LoadIR = 1; sb.push_back(mem[8'h00]);
    tick;
    LoadIR = 0;
    mem_respond(0);
    imem_ack = 1; imem_rdata = 8'hFF;
    tick;
    imem_ack = 0;
    total_cnt++; if ({IR, busy, ir_valid} !== {8'h1A, 2'b01}) $display("FAIL spurious got IR=%h busy=%b valid=%b want 1A 0 1", IR, busy, ir_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    set_pc(8'h05);
    LoadIR = 1; sb.push_back(mem[8'h05]);
    tick;
    LoadIR = 0;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_pre got ovr=%b want 0", overrun); else pass_cnt++;
    mem_respond(1);
    total_cnt++; if ({overrun, imem_req, busy} !== 3'b100) $display("FAIL b2b_ackcycle got ovr=%b req=%b busy=%b want 1 0 0", overrun, imem_req, busy); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h00] = 8'h1A;
    mem[8'h05] = 8'h2C;
    mem[8'hFF] = 8'h9E;
    test_reset;
    test_fetch;
    test_wait_states;
    test_jump_priority;
    test_wrap;
    test_reset_mid_fetch;
    test_spurious_ack;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
